// File: rtl/vpu_collect_pkg.sv
// ============================================================================
// vpu_collect_pkg
// Shared types and default widths for the VPU result collector.
// Revision: 1.0
// ============================================================================
`default_nettype none

package vpu_collect_pkg;

    localparam int VPU_WIDTH_DEF     = 4;
    localparam int DATA_WIDTH_IN_DEF = 32;
    localparam int LANE_DEPTH_DEF    = 4;
    localparam int ADDR_WIDTH_DEF    = 16;
    localparam int ROWS_WIDTH_DEF    = 16;
    localparam int STAT_WIDTH        = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } collect_state_e;

endpackage

`default_nettype wire

// File: rtl/vpu_lane_fifo.sv
// ============================================================================
// vpu_lane_fifo
// Per-lane skew FIFO; a push into a full FIFO succeeds when a pop coincides.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vpu_lane_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   c_full_cnt = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_cnt_one  = (AW+1)'(1);
    localparam logic [AW-1:0] c_ptr_one  = AW'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_count;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign o_full    = (r_count == c_full_cnt);
    assign o_empty   = (r_count == '0);
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage carries no reset; validity is tracked by the count alone.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + c_cnt_one;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - c_cnt_one;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/vpu_result_collector.sv
// ============================================================================
// vpu_result_collector
// Realigns skewed per-lane VPU results into rows and writes them out with a
// valid/ready handshake. Optional stall counter: VPU_COLLECT_STALL_CNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vpu_result_collector
    import vpu_collect_pkg::*;
#(
    parameter int VPU_WIDTH     = VPU_WIDTH_DEF,
    parameter int DATA_WIDTH_IN = DATA_WIDTH_IN_DEF,
    parameter int LANE_DEPTH    = LANE_DEPTH_DEF,
    parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF,
    parameter int ROWS_WIDTH    = ROWS_WIDTH_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cfg_start,
    input  logic [ADDR_WIDTH-1:0]           cfg_base_addr,
    input  logic [ROWS_WIDTH-1:0]           cfg_num_rows,
    input  logic signed [DATA_WIDTH_IN-1:0] vpu_data_out [VPU_WIDTH],
    input  logic                            vpu_valid_out [VPU_WIDTH],
    output logic                            wr_valid,
    input  logic                            wr_ready,
    output logic [ADDR_WIDTH-1:0]           wr_addr,
    output logic signed [DATA_WIDTH_IN-1:0] wr_data [VPU_WIDTH],
    output logic                            busy,
    output logic                            done,
    output logic                            overflow_err,
    output logic [STAT_WIDTH-1:0]           stat_stall_cycles
);

    localparam logic [ROWS_WIDTH-1:0] c_row_one  = ROWS_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] c_addr_one = ADDR_WIDTH'(1);

    collect_state_e r_state;
    collect_state_e w_state_nxt;

    logic [ADDR_WIDTH-1:0]           r_addr;
    logic [ADDR_WIDTH-1:0]           r_wr_addr;
    logic [ROWS_WIDTH-1:0]           r_num_rows;
    logic [ROWS_WIDTH-1:0]           r_rows_formed;
    logic [ROWS_WIDTH-1:0]           r_rows_written;
    logic                            r_wr_valid;
    logic                            r_overflow;
    logic signed [DATA_WIDTH_IN-1:0] r_wr_data [VPU_WIDTH];

    logic                            w_start_acc;
    logic                            w_run;
    logic                            w_out_free;
    logic                            w_pop;
    logic                            w_wr_fire;
    logic                            w_last_pop;
    logic                            w_last_write;
    logic [VPU_WIDTH-1:0]            w_empty;
    logic [VPU_WIDTH-1:0]            w_full;
    logic [VPU_WIDTH-1:0]            w_push;
    logic [VPU_WIDTH-1:0]            w_ovf;
    logic signed [DATA_WIDTH_IN-1:0] w_fifo_dout [VPU_WIDTH];

    assign w_start_acc  = (r_state == ST_IDLE) && cfg_start;
    assign w_run        = (r_state == ST_RUN);
    assign w_out_free   = !r_wr_valid || wr_ready;
    // A row pops only when every lane holds a word, so rows stay lane-aligned.
    assign w_pop        = w_run && (w_empty == '0) && w_out_free;
    assign w_wr_fire    = r_wr_valid && wr_ready;
    assign w_last_pop   = w_pop && (r_rows_formed == r_num_rows - c_row_one);
    assign w_last_write = w_wr_fire && (r_rows_written == r_num_rows - c_row_one);

    for (genvar gi = 0; gi < VPU_WIDTH; gi++) begin : g_lane
        logic                  w_req;
        logic [ROWS_WIDTH-1:0] r_cnt;

        assign w_req      = w_run && vpu_valid_out[gi] && (r_cnt < r_num_rows);
        assign w_push[gi] = w_req && (!w_full[gi] || w_pop);
        assign w_ovf[gi]  = w_req && w_full[gi] && !w_pop;

        always_ff @(posedge clk) begin
            if (rst || w_start_acc) begin
                r_cnt <= '0;
            end else if (w_push[gi]) begin
                r_cnt <= r_cnt + c_row_one;
            end
        end

        vpu_lane_fifo #(
            .DATA_WIDTH (DATA_WIDTH_IN),
            .DEPTH      (LANE_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .i_push  (w_push[gi]),
            .i_data  (vpu_data_out[gi]),
            .i_pop   (w_pop),
            .o_data  (w_fifo_dout[gi]),
            .o_full  (w_full[gi]),
            .o_empty (w_empty[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cfg_start) begin
                    w_state_nxt = (cfg_num_rows == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last_pop) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_last_write) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            ST_RUN, ST_DRAIN: busy = 1'b1;
            ST_DONE:          done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_valid     <= 1'b0;
            r_wr_addr      <= '0;
            r_addr         <= '0;
            r_num_rows     <= '0;
            r_rows_formed  <= '0;
            r_rows_written <= '0;
            r_overflow     <= 1'b0;
            for (int i = 0; i < VPU_WIDTH; i++) begin
                r_wr_data[i] <= '0;
            end
        end else if (w_start_acc) begin
            r_addr         <= cfg_base_addr;
            r_num_rows     <= cfg_num_rows;
            r_rows_formed  <= '0;
            r_rows_written <= '0;
            r_overflow     <= 1'b0;
        end else begin
            if (w_pop) begin
                r_wr_valid    <= 1'b1;
                r_wr_addr     <= r_addr;
                r_addr        <= r_addr + c_addr_one;
                r_rows_formed <= r_rows_formed + c_row_one;
                for (int i = 0; i < VPU_WIDTH; i++) begin
                    r_wr_data[i] <= w_fifo_dout[i];
                end
            end else if (w_wr_fire) begin
                r_wr_valid <= 1'b0;
            end
            if (w_wr_fire) begin
                r_rows_written <= r_rows_written + c_row_one;
            end
            if (|w_ovf) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign wr_valid     = r_wr_valid;
    assign wr_addr      = r_wr_addr;
    assign wr_data      = r_wr_data;
    assign overflow_err = r_overflow;

`ifdef VPU_COLLECT_STALL_CNT_EN
    logic [STAT_WIDTH-1:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst || w_start_acc) begin
            r_stall_cnt <= '0;
        end else if (r_wr_valid && !wr_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STAT_WIDTH'(1);
        end
    end

    assign stat_stall_cycles = r_stall_cnt;
`else
    assign stat_stall_cycles = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vpu_result_collector.sv
// ============================================================================
// tb_vpu_result_collector
// Directed self-checking bench for vpu_result_collector.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_vpu_result_collector;

`ifdef VPU_COLLECT_STALL_CNT_EN
    localparam logic [31:0] c_exp_stall = 32'd3;
`else
    localparam logic [31:0] c_exp_stall = 32'd0;
`endif

    logic               clk;
    logic               rst;
    logic               cfg_start;
    logic [15:0]        cfg_base_addr;
    logic [15:0]        cfg_num_rows;
    logic signed [31:0] vdata [4];
    logic               vvalid [4];
    logic               wr_valid;
    logic               wr_ready;
    logic [15:0]        wr_addr;
    logic signed [31:0] wdata [4];
    logic               busy;
    logic               done;
    logic               overflow_err;
    logic [31:0]        stat_stall_cycles;

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0]  q_addr [$];
    logic [127:0] q_data [$];

    vpu_result_collector dut (
        .clk               (clk),
        .rst               (rst),
        .cfg_start         (cfg_start),
        .cfg_base_addr     (cfg_base_addr),
        .cfg_num_rows      (cfg_num_rows),
        .vpu_data_out      (vdata),
        .vpu_valid_out     (vvalid),
        .wr_valid          (wr_valid),
        .wr_ready          (wr_ready),
        .wr_addr           (wr_addr),
        .wr_data           (wdata),
        .busy              (busy),
        .done              (done),
        .overflow_err      (overflow_err),
        .stat_stall_cycles (stat_stall_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Accepted writes, sampled mid-cycle while the handshake inputs are stable.
    always @(negedge clk) begin
        if (wr_valid && wr_ready && !rst) begin
            q_addr.push_back(wr_addr);
            q_data.push_back({wdata[3], wdata[2], wdata[1], wdata[0]});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] row4(input int l0, input int l1, input int l2, input int l3);
        return {32'(l3), 32'(l2), 32'(l1), 32'(l0)};
    endfunction

    task automatic set_lanes(input logic [3:0] mask, input int base_v);
        for (int i = 0; i < 4; i++) begin
            vvalid[i] = mask[i];
            vdata[i]  = base_v + i;
        end
    endtask

    task automatic start(input logic [15:0] base, input logic [15:0] rows);
        cfg_start     = 1'b1;
        cfg_base_addr = base;
        cfg_num_rows  = rows;
        tick();
        cfg_start     = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (done !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        chk({tag, "_done"}, 128'(done), 128'(1));
        tick();
    endtask

    initial begin
        rst           = 1'b1;
        cfg_start     = 1'b0;
        cfg_base_addr = '0;
        cfg_num_rows  = '0;
        wr_ready      = 1'b1;
        set_lanes(4'h0, 0);
        tick();
        tick();
        chk("rst_wr_valid", 128'(wr_valid), 128'(0));
        chk("rst_wr_addr", 128'(wr_addr), 128'(0));
        chk("rst_wr_data", {wdata[3], wdata[2], wdata[1], wdata[0]}, 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_ovf", 128'(overflow_err), 128'(0));
        chk("rst_stall", 128'(stat_stall_cycles), 128'(0));
        rst = 1'b0;
        tick();

        // Aligned rows, cycle-exact latency
        q_addr.delete(); q_data.delete();
        start(16'h0010, 16'd3);
        chk("al_busy", 128'(busy), 128'(1));
        set_lanes(4'hF, 15); tick();
        chk("al_lat1", 128'(wr_valid), 128'(0));
        set_lanes(4'hF, 19); tick();
        chk("al_v0", 128'(wr_valid), 128'(1));
        chk("al_a0", 128'(wr_addr), 128'(16'h10));
        chk("al_d0", {wdata[3], wdata[2], wdata[1], wdata[0]}, row4(15, 16, 17, 18));
        set_lanes(4'hF, 23); tick();
        chk("al_a1", 128'(wr_addr), 128'(16'h11));
        chk("al_d1", {wdata[3], wdata[2], wdata[1], wdata[0]}, row4(19, 20, 21, 22));
        set_lanes(4'h0, 0); tick();
        chk("al_a2", 128'(wr_addr), 128'(16'h12));
        chk("al_d2", {wdata[3], wdata[2], wdata[1], wdata[0]}, row4(23, 24, 25, 26));
        chk("al_nodone", 128'(done), 128'(0));
        tick();
        chk("al_done", 128'(done), 128'(1));
        chk("al_vlow", 128'(wr_valid), 128'(0));
        tick();
        chk("al_done_pulse", 128'(done), 128'(0));
        chk("al_idle", 128'(busy), 128'(0));
        chk("al_nwr", 128'(q_addr.size()), 128'(3));

        // Skewed lanes: lane i lags by i cycles
        q_addr.delete(); q_data.delete();
        start(16'h0040, 16'd2);
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 4; i++) begin
                vvalid[i] = (k == i) || (k == i + 1);
                vdata[i]  = 100 + 10 * (k - i) + i;
            end
            tick();
        end
        set_lanes(4'h0, 0);
        wait_done("sk");
        chk("sk_nwr", 128'(q_addr.size()), 128'(2));
        chk("sk_a0", 128'(q_addr[0]), 128'(16'h40));
        chk("sk_d0", q_data[0], row4(100, 101, 102, 103));
        chk("sk_a1", 128'(q_addr[1]), 128'(16'h41));
        chk("sk_d1", q_data[1], row4(110, 111, 112, 113));
        chk("sk_ovf", 128'(overflow_err), 128'(0));

        // Backpressure: three stalled cycles on the first row
        q_addr.delete(); q_data.delete();
        start(16'h0020, 16'd2);
        wr_ready = 1'b0;
        set_lanes(4'hF, 40); tick();
        set_lanes(4'hF, 44); tick();
        set_lanes(4'h0, 0);
        chk("bp_v", 128'(wr_valid), 128'(1));
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("bp_hold_a", 128'(wr_addr), 128'(16'h20));
            chk("bp_hold_d", {wdata[3], wdata[2], wdata[1], wdata[0]}, row4(40, 41, 42, 43));
        end
        wr_ready = 1'b1;
        tick();
        chk("bp_a1", 128'(wr_addr), 128'(16'h21));
        wait_done("bp");
        chk("bp_stall", 128'(stat_stall_cycles), 128'(c_exp_stall));
        chk("bp_nwr", 128'(q_addr.size()), 128'(2));
        chk("bp_d0", q_data[0], row4(40, 41, 42, 43));
        chk("bp_d1", q_data[1], row4(44, 45, 46, 47));

        // Overflow: lane 0 runs ahead while the others are idle
        q_addr.delete(); q_data.delete();
        start(16'h0000, 16'd5);
        for (int k = 1; k <= 6; k++) begin
            set_lanes(4'h1, 0);
            vdata[0] = k;
            tick();
            if (k == 4) chk("ov_pre", 128'(overflow_err), 128'(0));
            if (k == 5) chk("ov_set", 128'(overflow_err), 128'(1));
        end
        set_lanes(4'h0, 0);
        chk("ov_nodone", 128'(done), 128'(0));
        chk("ov_busy", 128'(busy), 128'(1));
        for (int k = 0; k < 5; k++) begin
            set_lanes(4'hF, 200 + 10 * k);
            tick();
        end
        set_lanes(4'h0, 0);
        wait_done("ov");
        chk("ov_nwr", 128'(q_addr.size()), 128'(5));
        chk("ov_d0", q_data[0], row4(1, 201, 202, 203));
        chk("ov_d3", q_data[3], row4(4, 231, 232, 233));
        chk("ov_d4", q_data[4], row4(210, 241, 242, 243));
        chk("ov_sticky", 128'(overflow_err), 128'(1));

        // Zero-row job
        q_addr.delete(); q_data.delete();
        start(16'h0080, 16'd0);
        chk("z_done", 128'(done), 128'(1));
        chk("z_busy", 128'(busy), 128'(0));
        tick();
        chk("z_done_pulse", 128'(done), 128'(0));
        chk("z_nwr", 128'(q_addr.size()), 128'(0));

        // Address wrap, with a start pulse ignored mid-job
        q_addr.delete(); q_data.delete();
        start(16'hFFFF, 16'd2);
        set_lanes(4'hF, 60); tick();
        cfg_start     = 1'b1;
        cfg_base_addr = 16'h0300;
        cfg_num_rows  = 16'd7;
        set_lanes(4'hF, 64); tick();
        cfg_start = 1'b0;
        set_lanes(4'h0, 0);
        wait_done("wr");
        chk("wr_nwr", 128'(q_addr.size()), 128'(2));
        chk("wr_a0", 128'(q_addr[0]), 128'(16'hFFFF));
        chk("wr_a1", 128'(q_addr[1]), 128'(16'h0000));
        chk("wr_d1", q_data[1], row4(64, 65, 66, 67));
        chk("wr_idle", 128'(busy), 128'(0));

        // Reset mid-job with a stalled row and partial lanes buffered
        start(16'h0050, 16'd4);
        wr_ready = 1'b0;
        set_lanes(4'hF, 80); tick();
        set_lanes(4'h3, 84); tick();
        set_lanes(4'h0, 0); tick();
        chk("rs_pre", 128'(wr_valid), 128'(1));
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        wr_ready = 1'b1;
        chk("rs_wr_valid", 128'(wr_valid), 128'(0));
        chk("rs_wr_addr", 128'(wr_addr), 128'(0));
        chk("rs_wr_data", {wdata[3], wdata[2], wdata[1], wdata[0]}, 128'(0));
        chk("rs_busy", 128'(busy), 128'(0));
        chk("rs_done", 128'(done), 128'(0));
        chk("rs_ovf", 128'(overflow_err), 128'(0));
        chk("rs_stall", 128'(stat_stall_cycles), 128'(0));
        q_addr.delete(); q_data.delete();
        start(16'h0060, 16'd1);
        set_lanes(4'hF, 90); tick();
        set_lanes(4'h0, 0);
        wait_done("rs");
        chk("rs_nwr", 128'(q_addr.size()), 128'(1));
        chk("rs_a0", 128'(q_addr[0]), 128'(16'h60));
        chk("rs_d0", q_data[0], row4(90, 91, 92, 93));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
